watch_fnd_ctrl: RTL and testbench

Downstream display stage for `watch_op`. It takes the binary `o_hour`/`o_min`/`o_sec` outputs and converts each field to two BCD digits with a sequential double-dabble. It then drives a 6-digit multiplexed common-anode 7-segment display (FND) with active-low digit enables and segments. Conversion triggers on any input change; the scan rate is runtime-programmable.

---
 rtl/watch_fnd_ctrl.sv | 153 +++++++++++++++
 tb/tb_watch_fnd_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/watch_fnd_ctrl.sv
// Binary hh:mm:ss to BCD via sequential double-dabble, driving a 6-digit
// multiplexed common-anode 7-segment display with active-low enables/segments.
module watch_fnd_ctrl #(
  parameter int CNT_BIT  = 32,
  parameter int SEC_BIT  = 6,
  parameter int MIN_BIT  = 6,
  parameter int HOUR_BIT = 6
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [SEC_BIT-1:0]  i_sec,
  input  logic [MIN_BIT-1:0]  i_min,
  input  logic [HOUR_BIT-1:0] i_hour,
  input  logic [CNT_BIT-1:0]  i_scan_th,
  output logic [5:0]          o_fnd_com,
  output logic [7:0]          o_fnd_data,
  output logic                o_busy
);

  localparam int MAXB_SM = (SEC_BIT > MIN_BIT) ? SEC_BIT : MIN_BIT;
  localparam int MAXB    = (MAXB_SM > HOUR_BIT) ? MAXB_SM : HOUR_BIT;
  localparam int SHW     = MAXB + 8;
  localparam int STW     = $clog2(MAXB + 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t             state, state_nxt;
  logic [SEC_BIT-1:0]  last_sec;
  logic [MIN_BIT-1:0]  last_min;
  logic [HOUR_BIT-1:0] last_hour;
  logic [SHW-1:0]     sh_sec, sh_min, sh_hour;
  logic [STW-1:0]     step;
  logic [5:0][3:0]    disp;
  logic [CNT_BIT-1:0] scan_cnt, th_eff;
  logic [2:0]         idx;
  logic               changed, scan_tc;
  logic [3:0]         cur_digit;
  logic [7:0]         data_nxt;
  logic [5:0]         com_nxt;

  // Narrower fields are zero-padded on the left; the extra leading zero shifts are harmless.
  function automatic logic [SHW-1:0] dd_step(input logic [SHW-1:0] v);
    logic [SHW-1:0] t;
    t = v;
    if (t[MAXB+3:MAXB] >= 4'd5)   t[MAXB+3:MAXB]   = t[MAXB+3:MAXB] + 4'd3;
    if (t[MAXB+7:MAXB+4] >= 4'd5) t[MAXB+7:MAXB+4] = t[MAXB+7:MAXB+4] + 4'd3;
    return {t[SHW-2:0], 1'b0};
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'h3F;
      4'd1: seg7 = 7'h06;
      4'd2: seg7 = 7'h5B;
      4'd3: seg7 = 7'h4F;
      4'd4: seg7 = 7'h66;
      4'd5: seg7 = 7'h6D;
      4'd6: seg7 = 7'h7D;
      4'd7: seg7 = 7'h07;
      4'd8: seg7 = 7'h7F;
      4'd9: seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  assign changed = ({i_hour, i_min, i_sec} != {last_hour, last_min, last_sec});
  assign o_busy  = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (changed) state_nxt = CONV;
      CONV:    if (step == STW'(MAXB - 1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_sec  <= '0;
      last_min  <= '0;
      last_hour <= '0;
      sh_sec    <= '0;
      sh_min    <= '0;
      sh_hour   <= '0;
      step      <= '0;
      disp      <= '0;
    end else begin
      case (state)
        IDLE: if (changed) begin
          last_sec  <= i_sec;
          last_min  <= i_min;
          last_hour <= i_hour;
          sh_sec    <= {8'd0, MAXB'(i_sec)};
          sh_min    <= {8'd0, MAXB'(i_min)};
          sh_hour   <= {8'd0, MAXB'(i_hour)};
          step      <= '0;
        end
        CONV: begin
          sh_sec  <= dd_step(sh_sec);
          sh_min  <= dd_step(sh_min);
          sh_hour <= dd_step(sh_hour);
          step    <= step + STW'(1);
        end
        DONE: disp <= {sh_hour[MAXB+7:MAXB+4], sh_hour[MAXB+3:MAXB],
                       sh_min[MAXB+7:MAXB+4],  sh_min[MAXB+3:MAXB],
                       sh_sec[MAXB+7:MAXB+4],  sh_sec[MAXB+3:MAXB]};
        default: ;
      endcase
    end
  end

  // A zero threshold behaves as one clock per digit.
  assign th_eff  = (i_scan_th == '0) ? CNT_BIT'(1) : i_scan_th;
  assign scan_tc = (scan_cnt >= th_eff - CNT_BIT'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_tc) begin
      scan_cnt <= '0;
      idx      <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + CNT_BIT'(1);
    end
  end

  always_comb begin
    cur_digit = disp[idx];
    com_nxt   = ~(6'b000001 << idx);
    data_nxt  = ~{1'b0, seg7(cur_digit)};
    // Colon-style blink: dp lit on min/hour ones while seconds ones is even.
    if ((idx == 3'd2 || idx == 3'd4) && !disp[0][0]) data_nxt[7] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_fnd_com  <= 6'b111110;
      o_fnd_data <= 8'hC0;
    end else begin
      o_fnd_com  <= com_nxt;
      o_fnd_data <= data_nxt;
    end
  end

endmodule

// File: tb/tb_watch_fnd_ctrl.sv
// Directed self-checking bench for watch_fnd_ctrl.
module tb_watch_fnd_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [5:0]  i_sec = '0, i_min = '0, i_hour = '0;
  logic [31:0] i_scan_th = 32'd1;
  logic [5:0]  o_fnd_com;
  logic [7:0]  o_fnd_data;
  logic        o_busy;

  int n_cmp = 0;
  int n_err = 0;

  watch_fnd_ctrl #(.CNT_BIT(32), .SEC_BIT(6), .MIN_BIT(6), .HOUR_BIT(6)) dut (
    .clk(clk), .reset_n(reset_n), .i_sec(i_sec), .i_min(i_min), .i_hour(i_hour),
    .i_scan_th(i_scan_th), .o_fnd_com(o_fnd_com), .o_fnd_data(o_fnd_data), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_time(input logic [5:0] h, input logic [5:0] m, input logic [5:0] s);
    i_hour = h;
    i_min  = m;
    i_sec  = s;
  endtask

  // Six consecutive samples with a 1-clock scan visit every digit once.
  task automatic capture_digits(output logic [5:0][7:0] d);
    logic [5:0] sel;
    d = '0;
    for (int j = 0; j < 6; j++) begin
      tick();
      for (int k = 0; k < 6; k++) begin
        sel = ~(6'b000001 << k);
        if (o_fnd_com == sel) d[k] = o_fnd_data;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    set_time(6'd23, 6'd59, 6'd58);
    i_scan_th = 32'd1;
    repeat (3) tick();
    n_cmp++; if (o_fnd_com !== 6'b111110) begin n_err++; $display("FAIL reset_com got=%b want=111110", o_fnd_com); end
    n_cmp++; if (o_fnd_data !== 8'hC0) begin n_err++; $display("FAIL reset_data got=%h want=c0", o_fnd_data); end
    n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", o_busy); end
  endtask

  task automatic test_convert();
    int busy_cnt;
    logic [5:0][7:0] got, exp;
    exp = {8'hA4, 8'h30, 8'h92, 8'h10, 8'h92, 8'h80};
    reset_n = 1'b1;
    busy_cnt = 0;
    for (int j = 0; j < 20; j++) begin
      tick();
      if (o_busy) busy_cnt++;
    end
    n_cmp++; if (busy_cnt != 7) begin n_err++; $display("FAIL convert_busy_cycles got=%0d want=7", busy_cnt); end
    capture_digits(got);
    for (int k = 0; k < 6; k++) begin
      n_cmp++;
      if (got[k] !== exp[k]) begin n_err++; $display("FAIL convert_digit%0d got=%h want=%h", k, got[k], exp[k]); end
    end
  endtask

  task automatic wait_digit0(input string name);
    logic [5:0] prev;
    logic       found;
    found = 1'b0;
    prev = o_fnd_com;
    for (int j = 0; j < 100 && !found; j++) begin
      tick();
      if (o_fnd_com == 6'b111110 && prev != 6'b111110) found = 1'b1;
      prev = o_fnd_com;
    end
    n_cmp++; if (!found) begin n_err++; $display("FAIL %s_align got=timeout want=digit0 start", name); end
  endtask

  task automatic test_scan_rate();
    logic [5:0] exp;
    i_scan_th = 32'd4;
    wait_digit0("scan4");
    for (int j = 1; j <= 24; j++) begin
      tick();
      exp = ~(6'b000001 << ((j / 4) % 6));
      n_cmp++;
      if (o_fnd_com !== exp) begin n_err++; $display("FAIL scan4_com[%0d] got=%b want=%b", j, o_fnd_com, exp); end
    end
    i_scan_th = 32'd0;
    wait_digit0("scan0");
    for (int j = 1; j <= 7; j++) begin
      tick();
      exp = ~(6'b000001 << (j % 6));
      n_cmp++;
      if (o_fnd_com !== exp) begin n_err++; $display("FAIL scan0_com[%0d] got=%b want=%b", j, o_fnd_com, exp); end
    end
    i_scan_th = 32'd1;
    repeat (2) tick();
  endtask

  task automatic test_change_during_conv();
    logic [16:0] bv;
    logic [5:0][7:0] got, exp;
    exp = {8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'h92, 8'h90};
    bv = '0;
    set_time(6'd0, 6'd0, 6'd58);
    for (int j = 0; j < 17; j++) begin
      tick();
      bv[j] = o_busy;
      if (j == 3) i_sec = 6'd59;
      if (j >= 8 && j <= 14) begin
        if (o_fnd_com == 6'b111110) begin
          n_cmp++;
          if (o_fnd_data !== 8'h80) begin n_err++; $display("FAIL mid_sec_ones got=%h want=80", o_fnd_data); end
        end
        if (o_fnd_com == 6'b111011) begin
          n_cmp++;
          if (o_fnd_data !== 8'h40) begin n_err++; $display("FAIL mid_min_ones_dp got=%h want=40", o_fnd_data); end
        end
      end
    end
    n_cmp++;
    if (bv !== 17'b00_1111111_0_1111111) begin
      n_err++; $display("FAIL chg_busy_trace got=%b want=%b", bv, 17'b00_1111111_0_1111111);
    end
    capture_digits(got);
    for (int k = 0; k < 6; k++) begin
      n_cmp++;
      if (got[k] !== exp[k]) begin n_err++; $display("FAIL chg_final_digit%0d got=%h want=%h", k, got[k], exp[k]); end
    end
  endtask

  task automatic test_reset_mid_conv();
    int busy_cnt;
    logic [5:0][7:0] got, exp;
    exp = {8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'hF8};
    set_time(6'd12, 6'd34, 6'd57);
    repeat (4) tick();
    reset_n = 1'b0;
    #1;
    n_cmp++; if (o_fnd_com !== 6'b111110) begin n_err++; $display("FAIL rstmid_com got=%b want=111110", o_fnd_com); end
    n_cmp++; if (o_fnd_data !== 8'hC0) begin n_err++; $display("FAIL rstmid_data got=%h want=c0", o_fnd_data); end
    n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got=%b want=0", o_busy); end
    repeat (2) tick();
    reset_n = 1'b1;
    busy_cnt = 0;
    for (int j = 0; j < 20; j++) begin
      tick();
      if (o_busy) busy_cnt++;
    end
    n_cmp++; if (busy_cnt != 7) begin n_err++; $display("FAIL rstmid_busy_cycles got=%0d want=7", busy_cnt); end
    capture_digits(got);
    for (int k = 0; k < 6; k++) begin
      n_cmp++;
      if (got[k] !== exp[k]) begin n_err++; $display("FAIL rstmid_digit%0d got=%h want=%h", k, got[k], exp[k]); end
    end
  endtask

  task automatic test_out_of_range();
    logic            done;
    logic [5:0][7:0] got;
    set_time(6'd0, 6'd63, 6'd1);
    tick();
    done = 1'b0;
    for (int j = 0; j < 50 && !done; j++) begin
      tick();
      if (!o_busy) done = 1'b1;
    end
    n_cmp++; if (!done) begin n_err++; $display("FAIL oor_idle got=busy want=idle"); end
    repeat (2) tick();
    capture_digits(got);
    n_cmp++; if (got[0] !== 8'hF9) begin n_err++; $display("FAIL oor_sec_ones got=%h want=f9", got[0]); end
    n_cmp++; if (got[2] !== 8'hB0) begin n_err++; $display("FAIL oor_min_ones got=%h want=b0", got[2]); end
    n_cmp++; if (got[3] !== 8'h82) begin n_err++; $display("FAIL oor_min_tens got=%h want=82", got[3]); end
  endtask

  initial begin
    test_reset();
    test_convert();
    test_scan_rate();
    test_change_during_conv();
    test_reset_mid_conv();
    test_out_of_range();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
